// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one RAM port between instruction fetch (IF) and data access (MEM).
// MEM wins ties; IF is forced through after STARVE_LIMIT consecutive MEM grants while it waits.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_ready,

  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,

  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wstrb,
  input  logic        ram_ack,
  input  logic [31:0] ram_rdata,

  output logic        stall_IF,
  output logic        stall_MEM
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_MEM} state_e;

  state_e      state_q, state_d;
  logic        ram_we_q, ram_we_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic [3:0]  ram_wstrb_q, ram_wstrb_d;
  logic [2:0]  starve_cnt_q, starve_cnt_d;
  logic        discard_q, discard_d;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v >= LIMIT) ? v : v + 3'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_wstrb_q  <= '0;
      starve_cnt_q <= '0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_wstrb_q  <= ram_wstrb_d;
      starve_cnt_q <= starve_cnt_d;
      discard_q    <= discard_d;
    end
  end

  // RAM operands are captured only on a grant, so they stay frozen until ram_ack.
  always_comb begin
    state_d      = state_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ram_wstrb_d  = ram_wstrb_q;
    starve_cnt_d = starve_cnt_q;
    discard_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req && !(if_req && starve_cnt_q == LIMIT)) begin
          state_d     = GNT_MEM;
          ram_we_d    = mem_we;
          ram_addr_d  = mem_addr;
          ram_wdata_d = mem_wdata;
          ram_wstrb_d = mem_wstrb;
          if (if_req) starve_cnt_d = sat_inc(starve_cnt_q);
        end else if (if_req) begin
          state_d      = GNT_IF;
          ram_we_d     = 1'b0;
          ram_addr_d   = if_addr;
          ram_wdata_d  = '0;
          ram_wstrb_d  = '0;
          starve_cnt_d = '0;
        end
      end
      GNT_IF: begin
        if (ram_ack) state_d = IDLE;
        else         discard_d = discard_q | if_flush;
      end
      GNT_MEM: begin
        if (ram_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A flushed fetch still finishes on the RAM side; only its ready pulse is suppressed.
  always_comb begin
    ram_req   = (state_q != IDLE);
    ram_we    = ram_we_q;
    ram_addr  = ram_addr_q;
    ram_wdata = ram_wdata_q;
    ram_wstrb = ram_wstrb_q;
    if_ready  = 1'b0;
    mem_ready = 1'b0;
    if_rdata  = '0;
    mem_rdata = '0;
    if (state_q == GNT_IF && ram_ack) begin
      if_rdata = ram_rdata;
      if_ready = !discard_q && !if_flush;
    end
    if (state_q == GNT_MEM && ram_ack) begin
      mem_rdata = ram_rdata;
      mem_ready = 1'b1;
    end
    stall_IF  = if_req & ~if_ready;
    stall_MEM = mem_req & ~mem_ready;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change on the falling edge, outputs are sampled 1ns later.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, mem_req, mem_we, ram_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic        if_ready, mem_ready, ram_req, ram_we, stall_IF, stall_MEM;
  logic [3:0]  ram_wstrb;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .stall_IF(stall_IF), .stall_MEM(stall_MEM)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Holds mem_req high, waits (bounded) for the MEM grant, acks at once and checks the ready pulse.
  task automatic mem_access(input logic [31:0] addr);
    int n;
    mem_req  = 1'b1;
    mem_addr = addr;
    n = 0;
    tick();
    while (!ram_req && n < 10) begin
      tick();
      n++;
    end
    chk("mem_grant_req", ram_req, 1'b1);
    chk("mem_grant_addr", ram_addr, addr);
    ram_ack = 1'b1;
    #1;
    chk("mem_access_ready", mem_ready, 1'b1);
    @(negedge clk);
    ram_ack = 1'b0;
    #1;
  endtask

  initial begin
    int  grants, if_pos, mem_done;
    bit  stall_ok, if_done;
    rst_n = 1'b0; if_req = 0; if_flush = 0; mem_req = 0; mem_we = 0; ram_ack = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0; ram_rdata = 0;

    #2;
    chk("rst_ram_req", ram_req, 1'b0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_wstrb", ram_wstrb, 4'h0);
    chk("rst_ready", {if_ready, mem_ready}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Single fetch, ack one cycle after ram_req.
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    chk("fetch_idle_stall", stall_IF, 1'b1);
    chk("fetch_idle_noreq", ram_req, 1'b0);
    tick();
    chk("fetch_ram_req", ram_req, 1'b1);
    chk("fetch_ram_addr", ram_addr, 32'h100);
    chk("fetch_ram_we", ram_we, 1'b0);
    chk("fetch_wait_ready", if_ready, 1'b0);
    @(negedge clk);
    ram_ack = 1'b1; ram_rdata = 32'h13;
    #1;
    chk("fetch_if_ready", if_ready, 1'b1);
    chk("fetch_if_rdata", if_rdata, 32'h13);
    chk("fetch_stall_clear", stall_IF, 1'b0);
    @(negedge clk);
    if_req = 1'b0; ram_ack = 1'b0;
    #1;
    chk("fetch_back_idle", ram_req, 1'b0);
    chk("fetch_single_pulse", if_ready, 1'b0);

    // Simultaneous requests: MEM first, IF on the next IDLE cycle.
    if_req = 1'b1; if_addr = 32'h104;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h2000; mem_wdata = 32'hDEADBEEF; mem_wstrb = 4'hF;
    tick();
    chk("tie_mem_we", ram_we, 1'b1);
    chk("tie_mem_addr", ram_addr, 32'h2000);
    chk("tie_mem_wdata", ram_wdata, 32'hDEADBEEF);
    chk("tie_mem_wstrb", ram_wstrb, 4'hF);
    chk("tie_stall_mem", stall_MEM, 1'b1);
    ram_ack = 1'b1; ram_rdata = 32'h0;
    #1;
    chk("tie_mem_ready", mem_ready, 1'b1);
    chk("tie_if_waiting", {if_ready, stall_IF}, 2'b01);
    @(negedge clk);
    mem_req = 1'b0; mem_we = 1'b0; ram_ack = 1'b0;
    #1;
    chk("tie_idle_between", ram_req, 1'b0);
    tick();
    chk("tie_if_grant_addr", ram_addr, 32'h104);
    chk("tie_if_grant_we", {ram_we, ram_wstrb}, 5'h0);
    ram_ack = 1'b1; ram_rdata = 32'h55;
    #1;
    chk("tie_if_ready", if_ready, 1'b1);
    chk("tie_if_rdata", if_rdata, 32'h55);
    @(negedge clk);
    if_req = 1'b0; ram_ack = 1'b0;
    #1;

    // Starvation: six MEM accesses with IF waiting; IF must win after the 4th.
    if_req = 1'b1; if_addr = 32'h200;
    mem_req = 1'b1; mem_addr = 32'h3000; mem_wstrb = 4'h0;
    grants = 0; if_pos = -1; mem_done = 0; stall_ok = 1; if_done = 0;
    for (int cyc = 0; cyc < 60 && (if_req || mem_req); cyc++) begin
      @(negedge clk);
      ram_ack = 1'b0;
      if (if_done) if_req = 1'b0;
      if (mem_done == 6) mem_req = 1'b0;
      #1;
      if (if_req && !stall_IF) stall_ok = 0;
      if (ram_req) begin
        if (ram_addr == 32'h200) if_pos = grants;
        grants++;
        ram_ack = 1'b1;
        #1;
        if (mem_ready) mem_done++;
        if (if_ready) if_done = 1;
      end
    end
    @(negedge clk);
    ram_ack = 1'b0; if_req = 1'b0; mem_req = 1'b0;
    #1;
    chk("starve_if_position", if_pos, 32'd4);
    chk("starve_mem_count", mem_done, 32'd6);
    chk("starve_total_grants", grants, 32'd7);
    chk("starve_stall_if", stall_ok, 1'b1);

    // Flush during a fetch that waits 3 cycles for ack.
    if_req = 1'b1; if_addr = 32'h300;
    tick();
    chk("flush_grant", ram_req, 1'b1);
    if_flush = 1'b1;
    #1;
    chk("flush_no_ready", if_ready, 1'b0);
    @(negedge clk);
    if_flush = 1'b0;
    #1;
    chk("flush_txn_alive", ram_req, 1'b1);
    tick();
    @(negedge clk);
    ram_ack = 1'b1; ram_rdata = 32'hABCD;
    #1;
    chk("flush_ack_ram_req", ram_req, 1'b1);
    chk("flush_ready_suppressed", if_ready, 1'b0);
    @(negedge clk);
    ram_ack = 1'b0; if_req = 1'b0;
    #1;
    chk("flush_back_idle", ram_req, 1'b0);

    // Reset in GNT_MEM with starve_cnt at its limit; afterwards MEM must win a tie again.
    if_req = 1'b1; if_addr = 32'h500; mem_we = 1'b0;
    for (int i = 0; i < 4; i++) mem_access(32'h4000);
    if_req = 1'b0;
    tick();
    chk("rstmid_in_gnt_mem", {ram_req, ram_addr}, {1'b1, 32'h4000});
    #2;
    rst_n = 1'b0; ram_ack = 1'b1;
    #1;
    chk("rstmid_ram_req_async", ram_req, 1'b0);
    chk("rstmid_no_mem_ready", mem_ready, 1'b0);
    chk("rstmid_ram_addr", ram_addr, 32'h0);
    @(negedge clk);
    ram_ack = 1'b0; rst_n = 1'b1;
    if_req = 1'b1; mem_req = 1'b1; mem_addr = 32'h4000;
    #1;
    chk("rstrel_no_early_grant", ram_req, 1'b0);
    tick();
    chk("rstrel_mem_wins", ram_addr, 32'h4000);
    ram_ack = 1'b1;
    #1;
    chk("rstrel_mem_ready", mem_ready, 1'b1);
    @(negedge clk);
    mem_req = 1'b0; ram_ack = 1'b0;
    tick();
    chk("rstrel_if_next", ram_addr, 32'h500);
    ram_ack = 1'b1;
    #1;
    chk("rstrel_if_ready", if_ready, 1'b1);
    @(negedge clk);
    ram_ack = 1'b0; if_req = 1'b0;
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, setting the consecutive MEM grants allowed while IF waits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have IF-side ports:
- if_req, input, 1, fetch request
- if_addr, input, 32, fetch address
- if_flush, input, 1, discard the in-flight fetch
- if_rdata, output, 32, fetch data
- if_ready, output, 1, fetch completes this cycle
REQ-005 The block SHALL have MEM-side ports:
- mem_req, input, 1, data-access request
- mem_we, input, 1, write when 1
- mem_addr, input, 32, data-access address
- mem_wdata, input, 32, write data
- mem_wstrb, input, 4, byte enables
- mem_rdata, output, 32, read data
- mem_ready, output, 1, data access completes this cycle
REQ-006 The block SHALL have RAM-side ports:
- ram_req, output, 1, transaction valid
- ram_we, output, 1, write
- ram_addr, output, 32, address
- ram_wdata, output, 32, write data
- ram_wstrb, output, 4, byte enables
- ram_ack, input, 1, completion
- ram_rdata, input, 32, read data
REQ-007 The block SHALL have stall ports:
- stall_IF, output, 1, fetch stall for the pipeline hazard logic
- stall_MEM, output, 1, data-access stall for the pipeline hazard logic

Function
REQ-008 The FSM SHALL have exactly three states: IDLE, GNT_IF and GNT_MEM.
REQ-009 In IDLE with only mem_req=1, the FSM SHALL go to GNT_MEM; with only if_req=1, it SHALL go to GNT_IF; with neither, it SHALL stay in IDLE.
REQ-010 In IDLE with both requests, the FSM SHALL grant MEM unless starve_cnt==STARVE_LIMIT, in which case it SHALL grant IF.
REQ-011 On entering a grant state, the block SHALL latch the winner's address, we, wdata and wstrb into ram_* registers; IF grants SHALL drive ram_we=0 and ram_wstrb=0.
REQ-012 ram_req SHALL be 1 exactly while the state is GNT_IF or GNT_MEM, and ram_* outputs SHALL stay stable until ram_ack.
REQ-013 The block SHALL ignore ram_ack while the state is IDLE.
REQ-014 In GNT_MEM with ram_ack=1, the block SHALL drive mem_ready=1 combinationally that cycle, drive mem_rdata=ram_rdata that cycle, and return to IDLE at the clock edge.
REQ-015 In GNT_IF with ram_ack=1, the block SHALL drive if_rdata=ram_rdata and return to IDLE; it SHALL drive if_ready=1 unless the discard flag is set or if_flush=1 that cycle.
REQ-016 The discard flag SHALL set on if_flush=1 while in GNT_IF, clear on leaving GNT_IF, and never abort the RAM transaction.
REQ-017 The block SHALL drive if_ready and mem_ready to 0 in all cycles other than those in REQ-014 and REQ-015.
REQ-018 Minimum latency SHALL be 1 cycle: a request seen in IDLE at cycle N gives ram_req=1 at N+1; ram_ack at N+1 gives ready at N+1.
REQ-019 Back-to-back transactions SHALL be supported: the FSM SHALL re-evaluate requests in the IDLE cycle right after completion, with no extra bubble.
REQ-020 starve_cnt SHALL be 3 bits wide with the following update rules:
- increment, saturating at STARVE_LIMIT, on each MEM grant made while if_req=1
- clear on each IF grant
- hold otherwise
REQ-021 The block SHALL compute stall_IF = if_req & ~if_ready and stall_MEM = mem_req & ~mem_ready combinationally.
REQ-022 Requesters SHALL hold req and operands stable until ready; the block does not check this.

Reset
REQ-023 While rst_n=0, and immediately on its assertion, the block SHALL set:
- state to IDLE
- ram_req, ram_we, if_ready and mem_ready to 0
- ram_addr, ram_wdata, ram_wstrb and starve_cnt to 0
- the discard flag to 0
REQ-024 Reset asserted mid-transaction SHALL drop that transaction with no ready pulse; after rst_n rises, the first grant SHALL occur no earlier than the first clock edge.

Verification
REQ-025 Scenario: if_req=1, if_addr=0x100, ram_ack one cycle after ram_req, ram_rdata=0x00000013 -> exactly one if_ready pulse with if_rdata=0x00000013 and ram_we=0.
REQ-026 Scenario: if_req=1 and mem_req=1 (we=1, addr=0x2000, wdata=0xDEADBEEF, wstrb=0xF) together -> MEM granted first and ram_* carries the MEM values; IF granted on the very next IDLE cycle.
REQ-027 Scenario: mem_req held high for 6 back-to-back accesses with if_req=1 and STARVE_LIMIT=4 -> IF granted after the 4th MEM access; stall_IF=1 every waiting cycle.
REQ-028 Scenario: if_flush pulsed during a GNT_IF that waits 3 cycles for ram_ack -> RAM transaction completes, if_ready stays 0, and the FSM returns to IDLE.
REQ-029 Scenario: rst_n driven low while in GNT_MEM before ram_ack -> ram_req=0 asynchronously; no mem_ready pulse; starve_cnt=0 after release.
